// File: rtl/brch_pred_pkg.sv
// rtl/brch_pred_pkg.sv - shared predictor constants and saturating counter step
package brch_pred_pkg;

  localparam logic PRED_TAKEN     = 1'b1;
  localparam logic PRED_NOT_TAKEN = 1'b0;
  localparam int   CTR_W_MAX      = 4;

  // Counter is carried at the widest legal width; callers pass their real width.
  function automatic logic [CTR_W_MAX-1:0] sat_ctr_next(
    input logic [CTR_W_MAX-1:0] ctr,
    input logic                 taken,
    input int unsigned          ctr_w
  );
    logic [CTR_W_MAX-1:0] top;
    top = CTR_W_MAX'((32'd1 << ctr_w) - 32'd1);
    if (taken) begin
      return (ctr >= top) ? top : ctr + CTR_W_MAX'(1);
    end
    return (ctr == '0) ? '0 : ctr - CTR_W_MAX'(1);
  endfunction

endpackage

// File: rtl/dyn_brnch_pred_sat_ctr_if.sv
// rtl/dyn_brnch_pred_sat_ctr_if.sv - IF/ID pipeline view of the branch predictor
interface dyn_brnch_pred_sat_ctr_if #(
  parameter int IDX_W  = 5,
  parameter int STAT_W = 16
);
  logic              brch_instr_detectd_IF;
  logic [IDX_W-1:0]  branch_addr_IF;
  logic              brch_instr_detectd_ID;
  logic              brch_hazard_stall;
  logic              flush_ID;
  logic              actual_brch_result;
  logic              prediction;
  logic              mispredict_ID;
  logic [STAT_W-1:0] mispredict_cnt;

  modport master (
    output brch_instr_detectd_IF, branch_addr_IF, brch_instr_detectd_ID,
           brch_hazard_stall, flush_ID, actual_brch_result,
    input  prediction, mispredict_ID, mispredict_cnt
  );

  modport slave (
    input  brch_instr_detectd_IF, branch_addr_IF, brch_instr_detectd_ID,
           brch_hazard_stall, flush_ID, actual_brch_result,
    output prediction, mispredict_ID, mispredict_cnt
  );
endinterface

// File: rtl/brch_pht_ram.sv
// rtl/brch_pht_ram.sv - pattern history table, async read, sync write, reset to INIT_CTR
module brch_pht_ram #(
  parameter int IDX_W    = 5,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [CTR_W-1:0] rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [CTR_W-1:0] wr_data
);

  localparam int DEPTH = 1 << IDX_W;

  logic [CTR_W-1:0] pht_q [DEPTH];
  logic [CTR_W-1:0] pht_d [DEPTH];

  assign rd_data = pht_q[rd_addr];

  always_comb begin
    pht_d = pht_q;
    if (wr_en) begin
      pht_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pht_q[i] <= CTR_W'(INIT_CTR);
      end
    end else begin
      pht_q <= pht_d;
    end
  end

endmodule

// File: rtl/dyn_brnch_pred_sat_ctr.sv
// rtl/dyn_brnch_pred_sat_ctr.sv - saturating-counter branch predictor with bypass and mispredict stats
module dyn_brnch_pred_sat_ctr
  import brch_pred_pkg::*;
#(
  parameter int IDX_W    = 5,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1,
  parameter int STAT_W   = 16
) (
  input logic                     clk,
  input logic                     rst,
  dyn_brnch_pred_sat_ctr_if.slave bp
);

  logic [CTR_W-1:0]  rd_ctr;
  logic [CTR_W-1:0]  eff_ctr;
  logic [CTR_W-1:0]  wr_ctr;
  logic              upd;
  logic              pred_if;
  logic              mispredict;

  logic [IDX_W-1:0]  id_idx_q, id_idx_d;
  logic              id_pred_q, id_pred_d;
  logic [CTR_W-1:0]  id_ctr_q, id_ctr_d;
  logic [STAT_W-1:0] cnt_q, cnt_d;

  // Reset outranks training so a branch pending in ID is dropped cleanly.
  assign upd = bp.brch_instr_detectd_ID & ~bp.brch_hazard_stall & ~bp.flush_ID & ~rst;

  // The counter value travels with the branch, so training never needs a second table read.
  assign wr_ctr = CTR_W'(sat_ctr_next(CTR_W_MAX'(id_ctr_q), bp.actual_brch_result, CTR_W));

  assign eff_ctr = (upd && (bp.branch_addr_IF == id_idx_q)) ? wr_ctr : rd_ctr;
  assign pred_if = eff_ctr[CTR_W-1] & bp.brch_instr_detectd_IF & ~rst;

  assign mispredict = upd & (id_pred_q != bp.actual_brch_result);

  brch_pht_ram #(
    .IDX_W    (IDX_W),
    .CTR_W    (CTR_W),
    .INIT_CTR (INIT_CTR)
  ) u_pht (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (bp.branch_addr_IF),
    .rd_data (rd_ctr),
    .wr_en   (upd),
    .wr_addr (id_idx_q),
    .wr_data (wr_ctr)
  );

  always_comb begin
    id_idx_d  = id_idx_q;
    id_pred_d = id_pred_q;
    id_ctr_d  = id_ctr_q;
    cnt_d     = cnt_q;
    if (!bp.brch_hazard_stall) begin
      id_idx_d  = bp.branch_addr_IF;
      id_pred_d = pred_if;
      id_ctr_d  = eff_ctr;
    end
    if (mispredict && (cnt_q != '1)) begin
      cnt_d = cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_idx_q  <= '0;
      id_pred_q <= PRED_NOT_TAKEN;
      id_ctr_q  <= CTR_W'(INIT_CTR);
      cnt_q     <= '0;
    end else begin
      id_idx_q  <= id_idx_d;
      id_pred_q <= id_pred_d;
      id_ctr_q  <= id_ctr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bp.prediction     = pred_if;
  assign bp.mispredict_ID  = mispredict;
  assign bp.mispredict_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_dyn_brnch_pred_sat_ctr.sv
// tb/tb_dyn_brnch_pred_sat_ctr.sv - directed bench for the saturating-counter predictor
module tb_dyn_brnch_pred_sat_ctr;
  import brch_pred_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       det_if = 1'b0;
  logic [4:0] addr_if = '0;
  logic       det_id = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       act = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dyn_brnch_pred_sat_ctr_if #(.IDX_W(5), .STAT_W(16)) if16 ();
  dyn_brnch_pred_sat_ctr_if #(.IDX_W(5), .STAT_W(2))  if2 ();

  assign if16.brch_instr_detectd_IF = det_if;
  assign if16.branch_addr_IF        = addr_if;
  assign if16.brch_instr_detectd_ID = det_id;
  assign if16.brch_hazard_stall     = stall;
  assign if16.flush_ID              = flush;
  assign if16.actual_brch_result    = act;
  assign if2.brch_instr_detectd_IF  = det_if;
  assign if2.branch_addr_IF         = addr_if;
  assign if2.brch_instr_detectd_ID  = det_id;
  assign if2.brch_hazard_stall      = stall;
  assign if2.flush_ID               = flush;
  assign if2.actual_brch_result     = act;

  dyn_brnch_pred_sat_ctr #(.IDX_W(5), .CTR_W(2), .INIT_CTR(1), .STAT_W(16)) dut16 (
    .clk (clk), .rst (rst), .bp (if16.slave)
  );
  dyn_brnch_pred_sat_ctr #(.IDX_W(5), .CTR_W(2), .INIT_CTR(1), .STAT_W(2)) dut2 (
    .clk (clk), .rst (rst), .bp (if2.slave)
  );

  task automatic drv(input logic idet, input logic [4:0] iaddr, input logic ddet,
                     input logic st, input logic fl, input logic a);
    det_if = idet; addr_if = iaddr; det_id = ddet; stall = st; flush = fl; act = a;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv(1, 3, 1, 0, 0, 1);
    step();
    step();
    #1;
    n_chk++; if (if16.prediction !== 1'b0) begin n_fail++; $display("FAIL rst_pred got=%b exp=0", if16.prediction); end
    n_chk++; if (if16.mispredict_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", if16.mispredict_cnt); end
    n_chk++; if (if16.mispredict_ID !== 1'b0) begin n_fail++; $display("FAIL rst_mis got=%b exp=0", if16.mispredict_ID); end
    rst = 1'b0;
    drv(1, 3, 0, 0, 0, 0);
    n_chk++; if (if16.prediction !== 1'b0) begin n_fail++; $display("FAIL post_rst_pred3 got=%b exp=0", if16.prediction); end
    n_chk++; if (if16.mispredict_cnt !== 16'd0) begin n_fail++; $display("FAIL post_rst_cnt got=%0d exp=0", if16.mispredict_cnt); end
    for (int i = 0; i < 32; i++) begin
      drv(1, 5'(i), 0, 0, 0, 0);
      n_chk++; if (if16.prediction !== 1'b0) begin n_fail++; $display("FAIL init_pred idx=%0d got=%b exp=0", i, if16.prediction); end
    end
  endtask

  task automatic test_hysteresis();
    logic [4:0] exp_pred [5];
    logic [4:0] exp_mis [5];
    logic [4:0] exp_act [5];
    do_reset();
    drv(1, 3, 0, 0, 0, 0);
    step();
    // counter 1 -> 2 -> 3 -> 3 -> 2; bypass makes each lookup see the post-update value
    exp_act  = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd0};
    exp_pred = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd0};
    exp_mis  = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd1};
    for (int i = 0; i < 4; i++) begin
      drv(1, 3, 1, 0, 0, exp_act[i][0]);
      n_chk++; if (if16.prediction !== exp_pred[i][0]) begin n_fail++; $display("FAIL hyst_pred step=%0d got=%b exp=%b", i, if16.prediction, exp_pred[i][0]); end
      n_chk++; if (if16.mispredict_ID !== exp_mis[i][0]) begin n_fail++; $display("FAIL hyst_mis step=%0d got=%b exp=%b", i, if16.mispredict_ID, exp_mis[i][0]); end
      step();
    end
    drv(1, 3, 0, 0, 0, 0);
    n_chk++; if (if16.prediction !== 1'b1) begin n_fail++; $display("FAIL hyst_hold_pred got=%b exp=1", if16.prediction); end
    n_chk++; if (if16.mispredict_cnt !== 16'd2) begin n_fail++; $display("FAIL hyst_cnt got=%0d exp=2", if16.mispredict_cnt); end
  endtask

  task automatic test_stall();
    do_reset();
    drv(1, 5, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drv(1, 5, 1, 1, 0, 1);
      n_chk++; if (if16.mispredict_ID !== 1'b0) begin n_fail++; $display("FAIL stall_mis cyc=%0d got=%b exp=0", i, if16.mispredict_ID); end
      n_chk++; if (if16.prediction !== 1'b0) begin n_fail++; $display("FAIL stall_pred cyc=%0d got=%b exp=0", i, if16.prediction); end
      step();
    end
    drv(1, 5, 1, 0, 0, 1);
    n_chk++; if (if16.mispredict_ID !== 1'b1) begin n_fail++; $display("FAIL release_mis got=%b exp=1", if16.mispredict_ID); end
    n_chk++; if (if16.prediction !== 1'b1) begin n_fail++; $display("FAIL release_pred got=%b exp=1", if16.prediction); end
    step();
    drv(1, 5, 0, 0, 0, 0);
    n_chk++; if (if16.mispredict_cnt !== 16'd1) begin n_fail++; $display("FAIL release_cnt got=%0d exp=1", if16.mispredict_cnt); end
    n_chk++; if (if16.mispredict_ID !== 1'b0) begin n_fail++; $display("FAIL after_release_mis got=%b exp=0", if16.mispredict_ID); end
    step();
    // one not-taken from 2 lands on 1 (predict 0); a double update would have left 2
    drv(1, 5, 1, 0, 0, 0);
    n_chk++; if (if16.prediction !== 1'b0) begin n_fail++; $display("FAIL single_upd_pred got=%b exp=0", if16.prediction); end
    n_chk++; if (if16.mispredict_ID !== 1'b1) begin n_fail++; $display("FAIL single_upd_mis got=%b exp=1", if16.mispredict_ID); end
    step();
    drv(0, 0, 0, 0, 0, 0);
    n_chk++; if (if16.mispredict_cnt !== 16'd2) begin n_fail++; $display("FAIL stall_cnt_end got=%0d exp=2", if16.mispredict_cnt); end
  endtask

  task automatic test_bypass();
    do_reset();
    drv(1, 7, 0, 0, 0, 0);
    step();
    drv(1, 7, 1, 0, 0, 1);
    n_chk++; if (if16.prediction !== 1'b1) begin n_fail++; $display("FAIL bypass_same_pred got=%b exp=1", if16.prediction); end
    step();
    drv(1, 8, 1, 0, 0, 1);
    n_chk++; if (if16.prediction !== 1'b0) begin n_fail++; $display("FAIL bypass_diff_pred got=%b exp=0", if16.prediction); end
    n_chk++; if (if16.mispredict_ID !== 1'b0) begin n_fail++; $display("FAIL bypass_diff_mis got=%b exp=0", if16.mispredict_ID); end
    step();
    drv(1, 7, 0, 0, 0, 0);
    n_chk++; if (if16.prediction !== 1'b1) begin n_fail++; $display("FAIL bypass_after7 got=%b exp=1", if16.prediction); end
    drv(1, 8, 0, 0, 0, 0);
    n_chk++; if (if16.prediction !== 1'b0) begin n_fail++; $display("FAIL bypass_after8 got=%b exp=0", if16.prediction); end
  endtask

  task automatic test_flush();
    do_reset();
    drv(1, 2, 0, 0, 0, 0);
    step();
    drv(1, 2, 1, 0, 1, 1);
    n_chk++; if (if16.mispredict_ID !== 1'b0) begin n_fail++; $display("FAIL flush_mis got=%b exp=0", if16.mispredict_ID); end
    n_chk++; if (if16.prediction !== 1'b0) begin n_fail++; $display("FAIL flush_pred got=%b exp=0", if16.prediction); end
    step();
    drv(1, 2, 1, 1, 1, 1);
    n_chk++; if (if16.mispredict_ID !== 1'b0) begin n_fail++; $display("FAIL flush_stall_mis got=%b exp=0", if16.mispredict_ID); end
    step();
    drv(1, 2, 0, 0, 0, 0);
    n_chk++; if (if16.mispredict_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=0", if16.mispredict_cnt); end
    step();
    // taken then not-taken returns to 1 only if the flushed branch left the counter at 1
    drv(1, 2, 1, 0, 0, 1);
    n_chk++; if (if16.mispredict_ID !== 1'b1) begin n_fail++; $display("FAIL flush_probe_mis got=%b exp=1", if16.mispredict_ID); end
    step();
    drv(1, 2, 1, 0, 0, 0);
    n_chk++; if (if16.prediction !== 1'b0) begin n_fail++; $display("FAIL flush_probe_pred got=%b exp=0", if16.prediction); end
    step();
  endtask

  task automatic test_stat_sat_and_mid_reset();
    logic [1:0] exp2 [4];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    drv(0, 10, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      drv(0, 10, 1, 0, 0, 1);
      n_chk++; if (if2.mispredict_ID !== 1'b1) begin n_fail++; $display("FAIL sat_mis n=%0d got=%b exp=1", i, if2.mispredict_ID); end
      step();
      drv(0, 10, 0, 0, 0, 0);
      n_chk++; if (if2.mispredict_cnt !== exp2[i]) begin n_fail++; $display("FAIL sat_cnt2 n=%0d got=%0d exp=%0d", i, if2.mispredict_cnt, exp2[i]); end
      n_chk++; if (if16.mispredict_cnt !== 16'(i + 1)) begin n_fail++; $display("FAIL sat_cnt16 n=%0d got=%0d exp=%0d", i, if16.mispredict_cnt, i + 1); end
    end
    drv(1, 10, 0, 0, 0, 0);
    n_chk++; if (if2.prediction !== 1'b1) begin n_fail++; $display("FAIL trained10_pred got=%b exp=1", if2.prediction); end
    step();
    rst = 1'b1;
    drv(1, 10, 1, 0, 0, 1);
    n_chk++; if (if2.mispredict_ID !== 1'b0) begin n_fail++; $display("FAIL midrst_mis got=%b exp=0", if2.mispredict_ID); end
    n_chk++; if (if2.mispredict_cnt !== 2'd0) begin n_fail++; $display("FAIL midrst_cnt_during got=%0d exp=0", if2.mispredict_cnt); end
    n_chk++; if (if2.prediction !== 1'b0) begin n_fail++; $display("FAIL midrst_pred_during got=%b exp=0", if2.prediction); end
    step();
    rst = 1'b0;
    drv(1, 10, 0, 0, 0, 0);
    n_chk++; if (if2.prediction !== 1'b0) begin n_fail++; $display("FAIL midrst_pred10 got=%b exp=0", if2.prediction); end
    n_chk++; if (if2.mispredict_cnt !== 2'd0) begin n_fail++; $display("FAIL midrst_cnt got=%0d exp=0", if2.mispredict_cnt); end
    n_chk++; if (if16.mispredict_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt16 got=%0d exp=0", if16.mispredict_cnt); end
    step();
    drv(1, 10, 1, 0, 0, 1);
    step();
    drv(1, 10, 1, 0, 0, 0);
    n_chk++; if (if2.prediction !== 1'b0) begin n_fail++; $display("FAIL dropped_upd_pred got=%b exp=0", if2.prediction); end
    step();
  endtask

  initial begin
    test_reset();
    test_hysteresis();
    test_stall();
    test_bypass();
    test_flush();
    test_stat_sat_and_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
